// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake between the UART sampler and its consumer (FIFO/APB control).
`timescale 1ns/1ps
interface uart_rx_sampler_if;
   logic [7:0] rx_byte;
   logic       rx_ready;
   logic       parity_err;
   logic       framing_err;
   logic       overflow;
   logic       read_rx_byte;

   modport master (
      output rx_byte, rx_ready, parity_err, framing_err, overflow,
      input  read_rx_byte
   );

   modport slave (
      input  rx_byte, rx_ready, parity_err, framing_err, overflow,
      output read_rx_byte
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// CoreUART receive stage: 16x oversampling, start-bit qualification, 7/8 data bits LSB first,
// optional parity, stop-bit check, and a one-deep output holding register with error flags.
`timescale 1ns/1ps
module uart_rx_sampler #(
   parameter int SYNC_RESET = 0
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              baud_clock,
   input  logic              rx,
   input  logic              bit8,
   input  logic              parity_en,
   input  logic              odd_n_even,
   uart_rx_sampler_if.master rx_bus,
   output logic              rx_idle
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t     state, state_n;
   logic [1:0] rst_q;
   logic       srst;
   logic       rx_s1, rx_s2;
   logic [2:0] filt;
   logic       rx_f;
   logic [3:0] samp_cnt;
   logic [2:0] bit_cnt;
   logic [2:0] last_bit;
   logic [7:0] shreg;
   logic [7:0] data_al;
   logic       armed, perr, done, stop_ok;
   logic       samp_clr, samp_inc, bit_clr, bit_inc, shift_en, par_cap, stop_cap, arm_set, arm_clr;

   // Synchronously released copy of aresetn; only used as an extra clear in sync mode.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) rst_q <= '0;
      else          rst_q <= {rst_q[0], 1'b1};
   end

   assign srst = (SYNC_RESET != 0) && !rst_q[1];

   // Two-flop synchroniser for rx, then a 3-sample filter advanced at the 16x rate.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         filt  <= '1;
      end else if (srst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         filt  <= '1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         if (baud_clock) filt <= {filt[1:0], rx_s2};
      end
   end

   assign rx_f     = (filt[0] & filt[1]) | (filt[0] & filt[2]) | (filt[1] & filt[2]);
   assign last_bit = bit8 ? 3'd7 : 3'd6;
   // Seven-bit frames leave the data in shreg[7:1]; shift it down so bit 7 reads as zero.
   assign data_al  = bit8 ? shreg : {1'b0, shreg[7:1]};
   assign rx_idle  = (state == S_IDLE);

   // Frame state register.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)  state <= S_IDLE;
      else if (srst) state <= S_IDLE;
      else           state <= state_n;
   end

   // Next state and datapath strobes; everything advances only on a baud tick.
   always_comb begin
      state_n  = state;
      samp_clr = 1'b0;
      samp_inc = 1'b0;
      bit_clr  = 1'b0;
      bit_inc  = 1'b0;
      shift_en = 1'b0;
      par_cap  = 1'b0;
      stop_cap = 1'b0;
      arm_set  = 1'b0;
      arm_clr  = 1'b0;
      if (baud_clock) begin
         case (state)
            S_IDLE: begin
               if (rx_f) begin
                  arm_set = 1'b1;
               end else if (armed) begin
                  state_n  = S_START;
                  samp_clr = 1'b1;
               end
            end
            S_START: begin
               samp_inc = 1'b1;
               if (samp_cnt == 4'd7) begin
                  if (!rx_f) begin
                     state_n  = S_DATA;
                     samp_clr = 1'b1;
                     bit_clr  = 1'b1;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end
            S_DATA: begin
               samp_inc = 1'b1;
               if (samp_cnt == 4'd15) begin
                  shift_en = 1'b1;
                  if (bit_cnt == last_bit) state_n = parity_en ? S_PARITY : S_STOP;
                  else                     bit_inc = 1'b1;
               end
            end
            S_PARITY: begin
               samp_inc = 1'b1;
               if (samp_cnt == 4'd15) begin
                  par_cap = 1'b1;
                  state_n = S_STOP;
               end
            end
            S_STOP: begin
               samp_inc = 1'b1;
               if (samp_cnt == 4'd15) begin
                  stop_cap = 1'b1;
                  state_n  = S_IDLE;
                  if (!rx_f) arm_clr = 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Counters, shift register, arming, parity result and the completion strobe.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         samp_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         armed    <= 1'b0;
         perr     <= 1'b0;
         done     <= 1'b0;
         stop_ok  <= 1'b0;
      end else if (srst) begin
         samp_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         armed    <= 1'b0;
         perr     <= 1'b0;
         done     <= 1'b0;
         stop_ok  <= 1'b0;
      end else begin
         if (samp_clr)      samp_cnt <= '0;
         else if (samp_inc) samp_cnt <= samp_cnt + 4'd1;
         if (bit_clr)       bit_cnt <= '0;
         else if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
         if (shift_en)      shreg <= {rx_f, shreg[7:1]};
         if (arm_clr)       armed <= 1'b0;
         else if (arm_set)  armed <= 1'b1;
         if (par_cap)       perr <= (^data_al) ^ rx_f ^ odd_n_even;
         if (stop_cap)      stop_ok <= rx_f;
         done <= stop_cap;
      end
   end

   // Output holding register: load on completion unless still full, else flag overflow.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rx_bus.rx_byte     <= '0;
         rx_bus.rx_ready    <= 1'b0;
         rx_bus.parity_err  <= 1'b0;
         rx_bus.framing_err <= 1'b0;
         rx_bus.overflow    <= 1'b0;
      end else if (srst) begin
         rx_bus.rx_byte     <= '0;
         rx_bus.rx_ready    <= 1'b0;
         rx_bus.parity_err  <= 1'b0;
         rx_bus.framing_err <= 1'b0;
         rx_bus.overflow    <= 1'b0;
      end else if (done) begin
         if (!rx_bus.rx_ready || rx_bus.read_rx_byte) begin
            rx_bus.rx_byte     <= data_al;
            rx_bus.parity_err  <= perr & parity_en;
            rx_bus.framing_err <= ~stop_ok;
            rx_bus.rx_ready    <= 1'b1;
            rx_bus.overflow    <= 1'b0;
         end else begin
            rx_bus.overflow <= 1'b1;
         end
      end else if (rx_bus.read_rx_byte && rx_bus.rx_ready) begin
         rx_bus.rx_ready    <= 1'b0;
         rx_bus.parity_err  <= 1'b0;
         rx_bus.framing_err <= 1'b0;
         rx_bus.overflow    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serial frames built from a bit-list model, expected bytes queued
// at issue time and checked by an independent monitor whenever the DUT loads its output register.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic baud_clock = 1'b0;
   logic rx = 1'b1;
   logic bit8 = 1'b1;
   logic parity_en = 1'b0;
   logic odd_n_even = 1'b0;
   logic rx_idle;

   uart_rx_sampler_if bus();

   uart_rx_sampler #(.SYNC_RESET(0)) dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .baud_clock (baud_clock),
      .rx         (rx),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .rx_bus     (bus),
      .rx_idle    (rx_idle)
   );

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_fail = 0;
   int   loads = 0;
   int   cyc = 0;
   int   ph = 0;
   int   last_load_cyc = 0;
   int   frame_start_cyc = 0;
   logic mon_prev = 1'b0;

   always #5 clk = ~clk;

   // 16x tick: one clk in four, changed away from the sampling edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         baud_clock = (ph == 3);
         ph = (ph + 1) % 4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: a load is rx_ready rising, or rx_ready staying high across a read (refill).
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!aresetn) begin
            mon_prev = 1'b0;
         end else begin
            if (bus.rx_ready && (!mon_prev || bus.read_rx_byte)) begin
               loads++;
               last_load_cyc = cyc;
               if (q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got 0x%0h expected none", bus.rx_byte);
               end else begin
                  e = q.pop_front();
                  chk("rx_byte", 32'(bus.rx_byte), 32'(e.data));
                  chk("parity_err", 32'(bus.parity_err), 32'(e.perr));
                  chk("framing_err", 32'(bus.framing_err), 32'(e.ferr));
               end
            end
            mon_prev = bus.rx_ready;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic hold(input logic b);
      rx = b;
      repeat (64) @(negedge clk);
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * 64) @(negedge clk);
   endtask

   task automatic align();
      do @(negedge clk); while (baud_clock !== 1'b1);
   endtask

   task automatic send_bits(input logic [7:0] data, input int nb, input logic pen,
                            input logic pbit, input logic stopb);
      frame_start_cyc = cyc;
      hold(1'b0);
      for (int i = 0; i < nb; i++) hold(data[i]);
      if (pen) hold(pbit);
      hold(stopb);
   endtask

   // Reference model: expected byte and flags from the line-level description of the frame.
   task automatic configure(input logic [7:0] data, input int nb, input logic pen, input logic odd,
                            input logic pbit, input logic stopb, input logic push);
      exp_t x;
      int   ones;
      int   mask;
      bit8       = (nb == 8);
      parity_en  = pen;
      odd_n_even = odd;
      ones = 0;
      for (int i = 0; i < nb; i++) ones += int'(data[i]);
      mask   = (1 << nb) - 1;
      x.data = 8'(int'(data) & mask);
      x.perr = pen && (((ones + int'(pbit)) % 2) != int'(odd));
      x.ferr = !stopb;
      if (push) q.push_back(x);
   endtask

   task automatic issue(input logic [7:0] data, input int nb, input logic pen, input logic odd,
                        input logic pbit, input logic stopb, input logic push);
      configure(data, nb, pen, odd, pbit, stopb, push);
      align();
      send_bits(data, nb, pen, pbit, stopb);
   endtask

   task automatic wait_ready(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (bus.rx_ready) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s: got rx_ready=0 expected rx_ready=1 within 400 clk", name);
      end
   endtask

   task automatic read_byte();
      @(negedge clk);
      bus.read_rx_byte = 1'b1;
      @(negedge clk);
      bus.read_rx_byte = 1'b0;
   endtask

   initial begin
      int   l0;
      int   lat;
      int   s;
      int   guard;
      logic [7:0] d;
      logic pen, odd, pb, sb, b8;
      int   ones;

      bus.read_rx_byte = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_rx_byte", 32'(bus.rx_byte), 32'h0);
      chk("reset_rx_ready", 32'(bus.rx_ready), 32'h0);
      chk("reset_parity_err", 32'(bus.parity_err), 32'h0);
      chk("reset_framing_err", 32'(bus.framing_err), 32'h0);
      chk("reset_overflow", 32'(bus.overflow), 32'h0);
      chk("reset_rx_idle", 32'(rx_idle), 32'h1);
      aresetn = 1'b1;
      idle(2);

      // T1: 8N1 0xA5
      issue(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t1_ready");
      chk("t1_overflow", 32'(bus.overflow), 32'h0);
      read_byte();
      chk("t1_ready_cleared", 32'(bus.rx_ready), 32'h0);
      idle(1);

      // T2: 7-bit even parity, wrong then right parity bit
      issue(8'h03, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_ready("t2a_ready");
      read_byte();
      idle(1);
      issue(8'h03, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t2b_ready");
      read_byte();
      idle(1);

      // T3: framing error with rx held low (break), then re-arm and 0x81
      l0 = loads;
      issue(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rx = 1'b0;
      repeat (40 * 64) @(negedge clk);
      chk("t3_single_ready", 32'(loads - l0), 32'd1);
      chk("t3_idle_in_break", 32'(rx_idle), 32'h1);
      read_byte();
      idle(2);
      chk("t3_no_retrigger", 32'(loads - l0), 32'd1);
      issue(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t3_ready_81");
      read_byte();
      idle(1);

      // T4: 5-tick glitch rejected
      l0 = loads;
      align();
      rx = 1'b0;
      repeat (20) @(negedge clk);
      idle(3);
      chk("t4_rx_idle", 32'(rx_idle), 32'h1);
      chk("t4_no_load", 32'(loads - l0), 32'd0);
      chk("t4_rx_ready", 32'(bus.rx_ready), 32'h0);

      // T5: overflow discards the second byte
      issue(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t5_ready_11");
      lat = last_load_cyc - frame_start_cyc;
      idle(1);
      issue(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      chk("t5_overflow_set", 32'(bus.overflow), 32'h1);
      chk("t5_byte_kept", 32'(bus.rx_byte), 32'h11);
      chk("t5_ready_held", 32'(bus.rx_ready), 32'h1);
      read_byte();
      chk("t5_overflow_cleared", 32'(bus.overflow), 32'h0);
      chk("t5_ready_cleared", 32'(bus.rx_ready), 32'h0);
      idle(1);

      // T5b: read lands on the same edge as the 0x22 completion
      issue(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t5b_ready_11");
      idle(1);
      if (lat < 1 || lat > 2000) begin
         n_vec++;
         n_fail++;
         $display("FAIL t5_latency: got %0d expected 1..2000 clk", lat);
         lat = 800;
      end
      configure(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      align();
      s = cyc;
      fork
         send_bits(8'h22, 8, 1'b0, 1'b0, 1'b1);
         begin
            guard = 0;
            while (cyc != s + lat && guard < 3000) begin
               @(negedge clk);
               guard++;
            end
            bus.read_rx_byte = 1'b1;
            @(negedge clk);
            bus.read_rx_byte = 1'b0;
         end
      join
      chk("t5b_no_overflow", 32'(bus.overflow), 32'h0);
      chk("t5b_ready", 32'(bus.rx_ready), 32'h1);
      chk("t5b_byte", 32'(bus.rx_byte), 32'h22);
      read_byte();
      idle(1);

      // T6: reset in the middle of data bit 4, with an unread byte still held
      issue(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t6_ready_81");
      idle(1);
      configure(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      align();
      d = 8'h5A;
      hold(1'b0);
      for (int i = 0; i < 4; i++) hold(d[i]);
      rx = d[4];
      repeat (32) @(negedge clk);
      aresetn = 1'b0;
      #1;
      chk("t6_rx_byte", 32'(bus.rx_byte), 32'h0);
      chk("t6_rx_ready", 32'(bus.rx_ready), 32'h0);
      chk("t6_parity_err", 32'(bus.parity_err), 32'h0);
      chk("t6_framing_err", 32'(bus.framing_err), 32'h0);
      chk("t6_overflow", 32'(bus.overflow), 32'h0);
      chk("t6_rx_idle", 32'(rx_idle), 32'h1);
      repeat (4) @(negedge clk);
      rx = 1'b1;
      aresetn = 1'b1;
      idle(2);
      issue(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ready("t6_ready_5a");
      read_byte();
      idle(1);

      // Randomised frames: format, data, parity correctness and stop bit all vary
      for (int k = 0; k < 24; k++) begin
         d   = 8'($urandom);
         b8  = 1'($urandom);
         pen = 1'($urandom);
         odd = 1'($urandom);
         ones = 0;
         for (int i = 0; i < (b8 ? 8 : 7); i++) ones += int'(d[i]);
         pb = 1'(ones % 2) ^ odd;
         if ($urandom_range(3, 0) == 0) pb = ~pb;
         sb = ($urandom_range(6, 0) != 0);
         issue(d, b8 ? 8 : 7, pen, odd, pb, sb, 1'b1);
         wait_ready("rand_ready");
         read_byte();
         idle(2);
      end

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
